// File: rtl/divide_if.sv
// Bus bundle for the free-running divide block: operands in, registered result out,
// plus the FSM state for observation.
interface divide_if;
  // No valid/ready handshake: N/D are sampled on the LOAD edge only.
  // Q/R change only on the DONE edge and hold their values otherwise.
  logic [7:0] N;
  logic [7:0] D;
  logic [7:0] Q;
  logic [7:0] R;
  logic [1:0] state;

  modport master (
    output N,
    output D,
    input  Q,
    input  R,
    input  state
  );

  modport slave (
    input  N,
    input  D,
    output Q,
    output R,
    output state
  );
endinterface

// File: rtl/divide.sv
// Free-running 8-bit sequential restoring divider (LOAD -> ITER x8 -> DONE -> LOAD).
// Optional macro DIVIDE_ZERO_FASTPATH_EN: a zero divisor skips ITER and goes straight to DONE.
module divide (
  input  logic     clk,
  input  logic     rst,
  divide_if.slave  bus
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       load_en;
  logic       iter_en;
  logic       done_en;

  logic [7:0] d_reg;
  logic [7:0] dvd_reg;
  logic [8:0] rem_reg;
  logic [2:0] cnt_reg;
  logic [7:0] q_reg;
  logic [7:0] r_reg;

  logic [9:0] shifted;
  logic [9:0] diff;
  logic       q_bit;
  logic [8:0] rem_next;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_LOAD: begin
`ifdef DIVIDE_ZERO_FASTPATH_EN
        if (bus.D == 8'd0) begin
          state_next = S_DONE;
        end else begin
          state_next = S_ITER;
        end
`else
        state_next = S_ITER;
`endif
      end
      S_ITER: begin
        if (cnt_reg == 3'd7) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  // Output decode
  always_comb begin
    load_en = 1'b0;
    iter_en = 1'b0;
    done_en = 1'b0;
    case (state)
      S_LOAD:  load_en = 1'b1;
      S_ITER:  iter_en = 1'b1;
      S_DONE:  done_en = 1'b1;
      default: load_en = 1'b0;
    endcase
  end

  // One restoring step. The remainder stays below D, so the shifted value fits
  // in 9 bits and diff[9] is a reliable borrow flag.
  assign shifted  = {rem_reg, dvd_reg[7]};
  assign diff     = shifted - {2'b00, d_reg};
  assign q_bit    = ~diff[9];
  assign rem_next = q_bit ? diff[8:0] : shifted[8:0];

  // Datapath: quotient bits shift into the dividend register as its bits are consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_reg   <= 8'd0;
      dvd_reg <= 8'd0;
      rem_reg <= 9'd0;
      cnt_reg <= 3'd0;
    end else if (load_en) begin
      d_reg   <= bus.D;
      dvd_reg <= bus.N;
      rem_reg <= 9'd0;
      cnt_reg <= 3'd0;
    end else if (iter_en) begin
      rem_reg <= rem_next;
      dvd_reg <= {dvd_reg[6:0], q_bit};
      cnt_reg <= cnt_reg + 3'd1;
    end
  end

  // Result registers, written only on the DONE edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= 8'd0;
      r_reg <= 8'd0;
    end else if (done_en) begin
`ifdef DIVIDE_ZERO_FASTPATH_EN
      if (d_reg == 8'd0) begin
        q_reg <= 8'hFF;
        r_reg <= dvd_reg;
      end else begin
        q_reg <= dvd_reg;
        r_reg <= rem_reg[7:0];
      end
`else
      q_reg <= dvd_reg;
      r_reg <= rem_reg[7:0];
`endif
    end
  end

  assign bus.Q     = q_reg;
  assign bus.R     = r_reg;
  assign bus.state = state;

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for divide: arithmetic reference model with a result queue,
// per-cycle comparison, and directed vectors with literal expected results.
module tb_divide;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  divide_if bus ();

  divide dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef DIVIDE_ZERO_FASTPATH_EN
  localparam int ZERO_EDGES = 2;
`else
  localparam int ZERO_EDGES = 10;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  exp_qv = 8'd0;
  logic [7:0]  exp_rv = 8'd0;
  int          wait_edges = -1;

  function automatic logic [15:0] ref_div(input logic [7:0] n, input logic [7:0] d);
    logic [7:0] q;
    logic [7:0] r;
    if (d == 8'd0) begin
      q = 8'hFF;
      r = n;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {q, r};
  endfunction

  // Reference model: a LOAD edge queues the arithmetic result, which becomes
  // visible 10 edges (2 for a fast-path zero divisor) after LOAD is entered.
  always @(posedge clk or negedge rst) begin
    logic [15:0] res;
    if (!rst) begin
      exp_q.delete();
      exp_qv     = 8'd0;
      exp_rv     = 8'd0;
      wait_edges = -1;
    end else if (wait_edges < 0) begin
      exp_q.push_back(ref_div(bus.N, bus.D));
      wait_edges = (bus.D == 8'd0) ? (ZERO_EDGES - 1) : 9;
    end else begin
      wait_edges = wait_edges - 1;
      if (wait_edges == 0) begin
        if (exp_q.size() > 0) begin
          res    = exp_q.pop_front();
          exp_qv = res[15:8];
          exp_rv = res[7:0];
        end
        wait_edges = -1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    checks = checks + 1;
    if (bus.Q !== exp_qv || bus.R !== exp_rv) begin
      errors = errors + 1;
      $display("FAIL model_cmp t=%0t: Q=%0d R=%0d expected Q=%0d R=%0d",
               $time, bus.Q, bus.R, exp_qv, exp_rv);
    end
  end

  task automatic check_lit(input string name, input logic [7:0] q, input logic [7:0] r);
    checks = checks + 1;
    if (bus.Q !== q || bus.R !== r) begin
      errors = errors + 1;
      $display("FAIL %s: Q=%0d R=%0d expected Q=%0d R=%0d", name, bus.Q, bus.R, q, r);
    end
  endtask

  // Called at a negedge just before a LOAD edge; returns at the negedge after the result edge.
  task automatic run_vec(input string name, input logic [7:0] n, input logic [7:0] d,
                         input logic [7:0] q, input logic [7:0] r, input int edges);
    bus.N = n;
    bus.D = d;
    repeat (edges) @(posedge clk);
    @(negedge clk);
    check_lit(name, q, r);
  endtask

  initial begin
    logic [7:0] rn;
    logic [7:0] rd;
    bus.N = 8'd10;
    bus.D = 8'd5;
    rst   = 1'b0;
    repeat (3) @(negedge clk);
    check_lit("reset_hold", 8'd0, 8'd0);
    rst = 1'b1;

    run_vec("n10_d5",    8'd10,  8'd5,   8'd2,   8'd0,   10);
    run_vec("n255_d1",   8'd255, 8'd1,   8'd255, 8'd0,   10);
    run_vec("n7_d9",     8'd7,   8'd9,   8'd0,   8'd7,   10);
    run_vec("n200_d7",   8'd200, 8'd7,   8'd28,  8'd4,   10);
    run_vec("n200_d0",   8'd200, 8'd0,   8'hFF,  8'd200, ZERO_EDGES);
    run_vec("n0_d13",    8'd0,   8'd13,  8'd0,   8'd0,   10);
    run_vec("n0_d0",     8'd0,   8'd0,   8'hFF,  8'd0,   ZERO_EDGES);
    run_vec("n255_d255", 8'd255, 8'd255, 8'd1,   8'd0,   10);
    run_vec("n254_d255", 8'd254, 8'd255, 8'd0,   8'd254, 10);

    // Operands change after the LOAD edge; the division in progress must ignore it
    bus.N = 8'd100;
    bus.D = 8'd3;
    @(posedge clk);
    @(negedge clk);
    bus.N = 8'd50;
    bus.D = 8'd5;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_lit("midchange_first", 8'd33, 8'd1);
    run_vec("midchange_next", 8'd50, 8'd5, 8'd10, 8'd0, 10);

    // Reset during ITER cycle 4 clears outputs at once and aborts the division
    bus.N = 8'd123;
    bus.D = 8'd4;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_lit("rst_abort_now", 8'd0, 8'd0);
    @(negedge clk);
    check_lit("rst_abort_hold", 8'd0, 8'd0);
    rst = 1'b1;
    run_vec("after_abort", 8'd90, 8'd4, 8'd22, 8'd2, 10);

    // A few extra operand pairs, checked by the model only
    for (int i = 0; i < 6; i++) begin
      rn = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(1, 255));
      bus.N = rn;
      bus.D = rd;
      repeat (10) @(posedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divide.md
DIVIDE -- requirements
Module: divide

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the clock and rst is the reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 N  input  8  unsigned dividend, sampled only in LOAD.
REQ-005 D  input  8  unsigned divisor, sampled only in LOAD.
REQ-006 Q  output  8  registered unsigned quotient of the last completed division.
REQ-007 R  output  8  registered unsigned remainder of the last completed division.

Function
REQ-008 The block SHALL run a free-running sequential restoring divider with FSM states LOAD, ITER and DONE; there is no start or busy handshake.
REQ-009 LOAD: one clk edge SHALL capture N and D into internal registers, clear the partial remainder (9-bit) and the iteration counter, then go to ITER.
REQ-010 ITER: each clk edge SHALL shift {remainder, dividend MSB} left by one, trial-subtract D, keep the difference and set quotient bit 1 if non-negative, else restore and set bit 0.
REQ-011 ITER SHALL last exactly 8 edges (counter 0..7), then go to DONE.
REQ-012 DONE: one clk edge SHALL write the quotient to Q and the remainder to R, then go to LOAD.
REQ-013 The result SHALL appear on Q/R at the 10th rising edge after LOAD is entered; the steady-state result period is 10 cycles.
REQ-014 Q and R SHALL hold their values between DONE updates.
REQ-015 Changes on N/D outside the LOAD edge SHALL NOT affect the division in progress.
REQ-016 All arithmetic is unsigned; Q = floor(N/D) and R = N mod D, with R < D for D != 0.
REQ-017 For D = 0 the result SHALL be Q = 8'hFF and R = N. This is the natural restoring outcome.
REQ-018 N = 0 SHALL yield Q = 0 and R = 0 for any nonzero D.

Reset
REQ-019 While rst = 0, Q and R SHALL be 8'h00, all internal registers SHALL be cleared, and the FSM SHALL be in LOAD, independent of clk.
REQ-020 Asserting rst mid-ITER SHALL abort the operation without updating Q/R to a partial result.
REQ-021 After rst deasserts, the first rising edge SHALL execute LOAD.

Configuration
REQ-022 With macro DIVIDE_ZERO_FASTPATH_EN defined, LOAD SHALL go directly to DONE when the captured D = 0, and DONE SHALL write Q = 8'hFF and R = N. The result appears 2 edges after LOAD is entered.
REQ-023 Without DIVIDE_ZERO_FASTPATH_EN, D = 0 SHALL take the normal 8-cycle ITER path with the REQ-017 result. All nonzero-D behaviour is identical in both builds.

Verification
REQ-024 Hold rst low, then release with N=10, D=5 -> Q=0 and R=0 during reset; Q=2 and R=0 after the 10th edge.
REQ-025 N=255, D=1 -> Q=255, R=0. N=7, D=9 -> Q=0, R=7. N=200, D=7 -> Q=28, R=4.
REQ-026 N=200, D=0 -> Q=8'hFF, R=200. This appears after 10 edges without DIVIDE_ZERO_FASTPATH_EN and after 2 edges with it.
REQ-027 Change N/D during ITER (N=100, D=3, then switch to 50/5) -> the result is Q=33, R=1; the next result is Q=10, R=0.
REQ-028 Assert rst at ITER cycle 4 -> Q and R are 0 immediately. After release, the first result appears 10 edges later.
